// File: rtl/control_logic.sv
// Command/control core of an 8259A-compatible interrupt controller (8086 mode).
// Decodes the ICW/OCW writes and holds the configuration. Runs the two-pulse
// INTA acknowledge and drives the vector byte. Also produces the mask, EOI,
// rotation, freeze and latch controls for the IRR/ISR/priority blocks, and the
// master/slave cascade signalling.
module control_logic (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] internal_data_bus,
    input  logic       ICW_1,
    input  logic       ICW_2_4,
    input  logic       OCW_1,
    input  logic       OCW_2,
    input  logic       OCW_3,
    input  logic       read,
    input  logic [2:0] casc_in,
    output logic [2:0] casc_out,
    output logic       casc_io,
    input  logic       slave_program_n,
    output logic       slave_program_or_enable_buffer,
    input  logic       interrupt_acknowledge_n,
    output logic       interrupt_to_cpu,
    output logic [7:0] control_logic_data,
    output logic       level_or_edge_toriggered_config,
    output logic       enable_read_register,
    output logic       read_register_isr_or_irr,
    input  logic [7:0] interrupt,
    input  logic [7:0] highest_level_in_service,
    output logic [7:0] interrupt_mask,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic       freeze,
    output logic       latch_in_service,
    output logic [7:0] clear_interrupt_request,
    output logic       single_or_cascade_config,
    output logic       call_address_interval_4_or_8_config,
    output logic       set_icw4_config,
    output logic       buffered_mode_config,
    output logic       buffered_master_or_slave_config,
    output logic       auto_eoi_config
);

    typedef enum logic [1:0] {CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} cmd_state_t;
    typedef enum logic [1:0] {ACK_IDLE, ACK_FIRST, ACK_SECOND} ack_state_t;

    cmd_state_t cmd_state;
    ack_state_t ack_state;
    logic       inta_prev;
    logic [4:0] vector_base;
    logic [7:0] cascade_device_config;
    logic       auto_rotate;
    logic [7:0] ack_level;
    logic       drive_data;

    logic       inta_fall;
    logic       inta_rise;
    logic       is_master;
    logic       drive_enable;
    logic       ack_done;
    logic [2:0] ack_index;
    logic [2:0] hlis_index;

    // One-hot to binary level number; the lowest set bit wins if several are set.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign inta_fall  = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise  = ~inta_prev & interrupt_acknowledge_n;
    assign ack_index  = onehot_to_index(ack_level);
    assign hlis_index = onehot_to_index(highest_level_in_service);

    // In buffered mode the SP/EN pin is an output, so the M/S bit decides the role.
    assign is_master = buffered_mode_config ? buffered_master_or_slave_config : slave_program_n;

    // A cascaded slave only answers when the master selects its ID on CAS.
    assign drive_enable = single_or_cascade_config | is_master |
                          (casc_in == cascade_device_config[2:0]);

    // Trailing edge of the second INTA pulse; an ICW1 in the same cycle cancels it.
    assign ack_done = inta_rise & (ack_state == ACK_SECOND) & ~ICW_1;

    assign enable_read_register = read & (ack_state == ACK_IDLE);

    // Master drives the slave ID on CAS only for levels that have a slave attached.
    assign casc_out = ((ack_state != ACK_IDLE) && is_master && !single_or_cascade_config &&
                       cascade_device_config[ack_index]) ? ack_index : 3'd0;

    // Buffer enable is active low and only used in buffered mode.
    assign slave_program_or_enable_buffer = buffered_mode_config ?
        ~(((ack_state == ACK_SECOND) & drive_data) | enable_read_register) : 1'b1;

    // Initialisation sequence, operation commands, EOI and rotation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_state                           <= CMD_READY;
            level_or_edge_toriggered_config     <= 1'b0;
            call_address_interval_4_or_8_config <= 1'b0;
            single_or_cascade_config            <= 1'b0;
            set_icw4_config                     <= 1'b0;
            vector_base                         <= '0;
            cascade_device_config               <= '0;
            auto_eoi_config                     <= 1'b0;
            buffered_master_or_slave_config     <= 1'b0;
            buffered_mode_config                <= 1'b0;
            interrupt_mask                      <= '0;
            read_register_isr_or_irr            <= 1'b0;
            auto_rotate                         <= 1'b0;
            priority_rotate                     <= 3'b111;
            end_of_interrupt                    <= '0;
        end else begin
            end_of_interrupt <= '0;
            if (ICW_1) begin
                level_or_edge_toriggered_config     <= internal_data_bus[3];
                call_address_interval_4_or_8_config <= internal_data_bus[2];
                single_or_cascade_config            <= internal_data_bus[1];
                set_icw4_config                     <= internal_data_bus[0];
                interrupt_mask                      <= '0;
                read_register_isr_or_irr            <= 1'b0;
                auto_eoi_config                     <= 1'b0;
                buffered_mode_config                <= 1'b0;
                buffered_master_or_slave_config     <= 1'b0;
                auto_rotate                         <= 1'b0;
                priority_rotate                     <= 3'b111;
                cmd_state                           <= WAIT_ICW2;
            end else begin
                if (ICW_2_4) begin
                    case (cmd_state)
                        WAIT_ICW2: begin
                            vector_base <= internal_data_bus[7:3];
                            if (!single_or_cascade_config) cmd_state <= WAIT_ICW3;
                            else if (set_icw4_config)      cmd_state <= WAIT_ICW4;
                            else                           cmd_state <= CMD_READY;
                        end
                        WAIT_ICW3: begin
                            cascade_device_config <= internal_data_bus;
                            cmd_state <= set_icw4_config ? WAIT_ICW4 : CMD_READY;
                        end
                        WAIT_ICW4: begin
                            auto_eoi_config                 <= internal_data_bus[1];
                            buffered_master_or_slave_config <= internal_data_bus[2];
                            buffered_mode_config            <= internal_data_bus[3];
                            cmd_state                       <= CMD_READY;
                        end
                        default: cmd_state <= CMD_READY;
                    endcase
                end
                if (OCW_1 && cmd_state == CMD_READY) interrupt_mask <= internal_data_bus;
                if (OCW_2) begin
                    case (internal_data_bus[7:5])
                        3'b001: end_of_interrupt <= highest_level_in_service;
                        3'b011: end_of_interrupt <= 8'b1 << internal_data_bus[2:0];
                        3'b101: begin
                            end_of_interrupt <= highest_level_in_service;
                            priority_rotate  <= hlis_index;
                        end
                        3'b111: begin
                            end_of_interrupt <= 8'b1 << internal_data_bus[2:0];
                            priority_rotate  <= internal_data_bus[2:0];
                        end
                        3'b110: priority_rotate <= internal_data_bus[2:0];
                        3'b100: auto_rotate <= 1'b1;
                        3'b000: auto_rotate <= 1'b0;
                        default: ;
                    endcase
                end
                if (OCW_3 && internal_data_bus[1]) read_register_isr_or_irr <= internal_data_bus[0];
                if (ack_done && auto_eoi_config) begin
                    end_of_interrupt <= ack_level;
                    if (auto_rotate) priority_rotate <= ack_index;
                end
            end
        end
    end

    // INTA acknowledge sequence, request to the CPU and cascade direction.
    // inta_prev resets high so an idle-high INTA never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_state               <= ACK_IDLE;
            inta_prev               <= 1'b1;
            freeze                  <= 1'b0;
            latch_in_service        <= 1'b0;
            clear_interrupt_request <= '0;
            control_logic_data      <= '0;
            ack_level               <= '0;
            drive_data              <= 1'b0;
            interrupt_to_cpu        <= 1'b0;
            casc_io                 <= 1'b0;
        end else begin
            inta_prev               <= interrupt_acknowledge_n;
            latch_in_service        <= 1'b0;
            clear_interrupt_request <= '0;
            casc_io                 <= is_master & ~single_or_cascade_config;
            case (ack_state)
                ACK_IDLE: begin
                    if (inta_fall) begin
                        freeze                  <= 1'b1;
                        latch_in_service        <= 1'b1;
                        clear_interrupt_request <= interrupt;
                        ack_level               <= interrupt;
                        interrupt_to_cpu        <= 1'b0;
                        ack_state               <= ACK_FIRST;
                    end else if (interrupt != 8'h00) begin
                        interrupt_to_cpu <= 1'b1;
                    end
                end
                ACK_FIRST: begin
                    if (inta_fall) begin
                        drive_data <= drive_enable;
                        if (drive_enable) control_logic_data <= {vector_base, ack_index};
                        ack_state <= ACK_SECOND;
                    end
                end
                ACK_SECOND: begin
                    if (inta_rise) begin
                        freeze             <= 1'b0;
                        control_logic_data <= '0;
                        drive_data         <= 1'b0;
                        ack_state          <= ACK_IDLE;
                    end
                end
                default: ack_state <= ACK_IDLE;
            endcase
            if (ICW_1) begin
                freeze             <= 1'b0;
                control_logic_data <= '0;
                drive_data         <= 1'b0;
                ack_state          <= ACK_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_control_logic.sv
// Directed bench for control_logic: initialisation, OCWs, acknowledge, cascade.
module tb_control_logic;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] internal_data_bus;
    logic       ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3, read;
    logic [2:0] casc_in;
    logic [2:0] casc_out;
    logic       casc_io;
    logic       slave_program_n;
    logic       slave_program_or_enable_buffer;
    logic       interrupt_acknowledge_n;
    logic       interrupt_to_cpu;
    logic [7:0] control_logic_data;
    logic       level_or_edge_toriggered_config;
    logic       enable_read_register;
    logic       read_register_isr_or_irr;
    logic [7:0] interrupt;
    logic [7:0] highest_level_in_service;
    logic [7:0] interrupt_mask;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic       freeze;
    logic       latch_in_service;
    logic [7:0] clear_interrupt_request;
    logic       single_or_cascade_config, call_address_interval_4_or_8_config, set_icw4_config;
    logic       buffered_mode_config, buffered_master_or_slave_config, auto_eoi_config;

    int checks = 0;
    int failures = 0;

    control_logic dut (
        .clk(clk), .reset_n(reset_n), .internal_data_bus(internal_data_bus),
        .ICW_1(ICW_1), .ICW_2_4(ICW_2_4), .OCW_1(OCW_1), .OCW_2(OCW_2), .OCW_3(OCW_3),
        .read(read), .casc_in(casc_in), .casc_out(casc_out), .casc_io(casc_io),
        .slave_program_n(slave_program_n),
        .slave_program_or_enable_buffer(slave_program_or_enable_buffer),
        .interrupt_acknowledge_n(interrupt_acknowledge_n), .interrupt_to_cpu(interrupt_to_cpu),
        .control_logic_data(control_logic_data),
        .level_or_edge_toriggered_config(level_or_edge_toriggered_config),
        .enable_read_register(enable_read_register),
        .read_register_isr_or_irr(read_register_isr_or_irr), .interrupt(interrupt),
        .highest_level_in_service(highest_level_in_service), .interrupt_mask(interrupt_mask),
        .end_of_interrupt(end_of_interrupt), .priority_rotate(priority_rotate), .freeze(freeze),
        .latch_in_service(latch_in_service), .clear_interrupt_request(clear_interrupt_request),
        .single_or_cascade_config(single_or_cascade_config),
        .call_address_interval_4_or_8_config(call_address_interval_4_or_8_config),
        .set_icw4_config(set_icw4_config), .buffered_mode_config(buffered_mode_config),
        .buffered_master_or_slave_config(buffered_master_or_slave_config),
        .auto_eoi_config(auto_eoi_config)
    );

    always #5 clk = ~clk;

    // Stimulus tasks start and end just after a falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // which: 0=ICW1 1=ICW2_4 2=OCW1 3=OCW2 4=OCW3
    task automatic strobe(input int which, input logic [7:0] d);
        internal_data_bus = d;
        ICW_1 = (which == 0); ICW_2_4 = (which == 1); OCW_1 = (which == 2);
        OCW_2 = (which == 3); OCW_3 = (which == 4);
        @(negedge clk);
        ICW_1 = 0; ICW_2_4 = 0; OCW_1 = 0; OCW_2 = 0; OCW_3 = 0;
    endtask

    task automatic test_reset;
        reset_n = 0; internal_data_bus = 0; ICW_1 = 0; ICW_2_4 = 0; OCW_1 = 0; OCW_2 = 0; OCW_3 = 0;
        read = 0; casc_in = 0; slave_program_n = 1; interrupt_acknowledge_n = 1;
        interrupt = 0; highest_level_in_service = 0;
        tick(3);
        checks++; if (priority_rotate !== 3'd7) begin failures++; $display("FAIL reset_rotate: got %0d expected 7", priority_rotate); end
        checks++; if (slave_program_or_enable_buffer !== 1'b1) begin failures++; $display("FAIL reset_spen: got %b expected 1", slave_program_or_enable_buffer); end
        checks++; if ({interrupt_to_cpu, freeze, latch_in_service, casc_io, casc_out} !== 7'd0) begin failures++; $display("FAIL reset_ctrl: got %b expected 0", {interrupt_to_cpu, freeze, latch_in_service, casc_io, casc_out}); end
        checks++; if ({interrupt_mask, control_logic_data, end_of_interrupt, clear_interrupt_request} !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", {interrupt_mask, control_logic_data, end_of_interrupt, clear_interrupt_request}); end
        checks++; if ({level_or_edge_toriggered_config, call_address_interval_4_or_8_config, single_or_cascade_config, set_icw4_config, buffered_mode_config, buffered_master_or_slave_config, auto_eoi_config, read_register_isr_or_irr, enable_read_register} !== 9'd0) begin failures++; $display("FAIL reset_cfg: got nonzero config, expected 0"); end
        reset_n = 1;
        tick(1);
    endtask

    task automatic test_icw_single;
        strobe(0, 8'h0F);
        checks++; if ({level_or_edge_toriggered_config, call_address_interval_4_or_8_config, single_or_cascade_config, set_icw4_config} !== 4'b1111) begin failures++; $display("FAIL icw1_bits: got %b expected 1111", {level_or_edge_toriggered_config, call_address_interval_4_or_8_config, single_or_cascade_config, set_icw4_config}); end
        strobe(1, 8'h04);
        strobe(1, 8'h02);
        checks++; if (auto_eoi_config !== 1'b1 || buffered_mode_config !== 1'b0) begin failures++; $display("FAIL icw4_aeoi: got aeoi=%b buf=%b expected 1 0", auto_eoi_config, buffered_mode_config); end
        strobe(2, 8'h5A);
        checks++; if (interrupt_mask !== 8'h5A) begin failures++; $display("FAIL single_ready: got %h expected 5a", interrupt_mask); end
        checks++; if (casc_io !== 1'b0) begin failures++; $display("FAIL single_cascio: got %b expected 0", casc_io); end
    endtask

    task automatic test_icw_cascade;
        slave_program_n = 0;
        strobe(0, 8'h11);
        checks++; if (interrupt_mask !== 8'h00 || auto_eoi_config !== 1'b0) begin failures++; $display("FAIL icw1_clear: got mask=%h aeoi=%b expected 00 0", interrupt_mask, auto_eoi_config); end
        strobe(1, 8'h40);
        strobe(2, 8'hFF);
        checks++; if (interrupt_mask !== 8'h00) begin failures++; $display("FAIL ocw1_in_init: got %h expected 00", interrupt_mask); end
        strobe(1, 8'h04);
        strobe(1, 8'h0C);
        checks++; if ({buffered_mode_config, buffered_master_or_slave_config, auto_eoi_config, single_or_cascade_config} !== 4'b1100) begin failures++; $display("FAIL icw4_cfg: got %b expected 1100", {buffered_mode_config, buffered_master_or_slave_config, auto_eoi_config, single_or_cascade_config}); end
    endtask

    task automatic test_ocw1;
        strobe(2, 8'hA5);
        checks++; if (interrupt_mask !== 8'hA5) begin failures++; $display("FAIL ocw1_mask: got %h expected a5", interrupt_mask); end
        checks++; if (casc_io !== 1'b1) begin failures++; $display("FAIL master_cascio: got %b expected 1", casc_io); end
    endtask

    task automatic test_ocw2;
        highest_level_in_service = 8'h10;
        strobe(3, 8'h20);
        checks++; if (end_of_interrupt !== 8'h10) begin failures++; $display("FAIL eoi_nonspec: got %h expected 10", end_of_interrupt); end
        tick(1);
        checks++; if (end_of_interrupt !== 8'h00) begin failures++; $display("FAIL eoi_pulse: got %h expected 00", end_of_interrupt); end
        strobe(3, 8'hE3);
        checks++; if (end_of_interrupt !== 8'h08 || priority_rotate !== 3'd3) begin failures++; $display("FAIL eoi_rot_spec: got %h/%0d expected 08/3", end_of_interrupt, priority_rotate); end
        strobe(3, 8'hC5);
        checks++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd5) begin failures++; $display("FAIL set_prio: got %h/%0d expected 00/5", end_of_interrupt, priority_rotate); end
        highest_level_in_service = 8'h40;
        strobe(3, 8'hA0);
        checks++; if (end_of_interrupt !== 8'h40 || priority_rotate !== 3'd6) begin failures++; $display("FAIL eoi_rot_nonspec: got %h/%0d expected 40/6", end_of_interrupt, priority_rotate); end
        highest_level_in_service = 8'h00;
    endtask

    task automatic test_ocw3;
        strobe(4, 8'h0B);
        read = 1;
        tick(1);
        checks++; if (read_register_isr_or_irr !== 1'b1 || enable_read_register !== 1'b1) begin failures++; $display("FAIL ocw3_isr: got ris=%b en=%b expected 1 1", read_register_isr_or_irr, enable_read_register); end
        checks++; if (slave_program_or_enable_buffer !== 1'b0) begin failures++; $display("FAIL buf_read_en: got %b expected 0", slave_program_or_enable_buffer); end
        strobe(4, 8'h08);
        checks++; if (read_register_isr_or_irr !== 1'b1) begin failures++; $display("FAIL ocw3_hold: got %b expected 1", read_register_isr_or_irr); end
        strobe(4, 8'h0A);
        read = 0;
        tick(1);
        checks++; if (read_register_isr_or_irr !== 1'b0 || slave_program_or_enable_buffer !== 1'b1) begin failures++; $display("FAIL ocw3_irr: got ris=%b spen=%b expected 0 1", read_register_isr_or_irr, slave_program_or_enable_buffer); end
    endtask

    task automatic test_acknowledge;
        slave_program_n = 1;
        strobe(0, 8'h11); strobe(1, 8'h40); strobe(1, 8'h08); strobe(1, 8'h0E);
        interrupt = 8'h08;
        tick(1);
        checks++; if (interrupt_to_cpu !== 1'b1) begin failures++; $display("FAIL int_rise: got %b expected 1", interrupt_to_cpu); end
        interrupt_acknowledge_n = 0;
        tick(1);
        checks++; if (interrupt_to_cpu !== 1'b0 || freeze !== 1'b1 || latch_in_service !== 1'b1) begin failures++; $display("FAIL inta1_ctrl: got int=%b frz=%b lat=%b expected 0 1 1", interrupt_to_cpu, freeze, latch_in_service); end
        checks++; if (clear_interrupt_request !== 8'h08) begin failures++; $display("FAIL inta1_clear: got %h expected 08", clear_interrupt_request); end
        checks++; if (casc_out !== 3'd3) begin failures++; $display("FAIL casc_out: got %0d expected 3", casc_out); end
        interrupt = 8'h00;
        read = 1;
        tick(1);
        checks++; if (latch_in_service !== 1'b0 || clear_interrupt_request !== 8'h00 || enable_read_register !== 1'b0) begin failures++; $display("FAIL inta1_pulse: got lat=%b clr=%h en=%b expected 0 00 0", latch_in_service, clear_interrupt_request, enable_read_register); end
        read = 0;
        interrupt_acknowledge_n = 1;
        tick(1);
        interrupt_acknowledge_n = 0;
        tick(1);
        checks++; if (control_logic_data !== 8'h43) begin failures++; $display("FAIL vector: got %h expected 43", control_logic_data); end
        checks++; if (slave_program_or_enable_buffer !== 1'b0) begin failures++; $display("FAIL buf_vec_en: got %b expected 0", slave_program_or_enable_buffer); end
        interrupt_acknowledge_n = 1;
        tick(1);
        checks++; if (freeze !== 1'b0 || control_logic_data !== 8'h00) begin failures++; $display("FAIL ack_end: got frz=%b data=%h expected 0 00", freeze, control_logic_data); end
        checks++; if (end_of_interrupt !== 8'h08 || priority_rotate !== 3'd7) begin failures++; $display("FAIL aeoi: got %h/%0d expected 08/7", end_of_interrupt, priority_rotate); end
        tick(1);
        checks++; if (end_of_interrupt !== 8'h00 || casc_out !== 3'd0) begin failures++; $display("FAIL aeoi_pulse: got %h/%0d expected 00/0", end_of_interrupt, casc_out); end
    endtask

    task automatic test_abort;
        interrupt = 8'h02;
        tick(1);
        interrupt_acknowledge_n = 0;
        tick(1);
        interrupt = 8'h00;
        checks++; if (freeze !== 1'b1) begin failures++; $display("FAIL abort_pre: got %b expected 1", freeze); end
        strobe(0, 8'h13);
        checks++; if (freeze !== 1'b0 || priority_rotate !== 3'd7) begin failures++; $display("FAIL abort_freeze: got %b/%0d expected 0/7", freeze, priority_rotate); end
        interrupt_acknowledge_n = 1;
        tick(2);
        checks++; if (control_logic_data !== 8'h00 || end_of_interrupt !== 8'h00) begin failures++; $display("FAIL abort_idle: got %h/%h expected 00/00", control_logic_data, end_of_interrupt); end
    endtask

    task automatic test_slave;
        slave_program_n = 0;
        strobe(0, 8'h11); strobe(1, 8'h80); strobe(1, 8'h02); strobe(1, 8'h01);
        for (int pass = 0; pass < 2; pass++) begin
            casc_in = (pass == 0) ? 3'd2 : 3'd5;
            interrupt = 8'h01;
            tick(1);
            interrupt_acknowledge_n = 0; tick(1);
            interrupt = 8'h00;
            interrupt_acknowledge_n = 1; tick(1);
            interrupt_acknowledge_n = 0; tick(1);
            if (pass == 0) begin
                checks++; if (control_logic_data !== 8'h80 || casc_io !== 1'b0 || casc_out !== 3'd0) begin failures++; $display("FAIL slave_match: got %h io=%b out=%0d expected 80 0 0", control_logic_data, casc_io, casc_out); end
                checks++; if (slave_program_or_enable_buffer !== 1'b1) begin failures++; $display("FAIL nonbuf_spen: got %b expected 1", slave_program_or_enable_buffer); end
            end else begin
                checks++; if (control_logic_data !== 8'h00 || freeze !== 1'b1) begin failures++; $display("FAIL slave_other: got %h frz=%b expected 00 1", control_logic_data, freeze); end
            end
            interrupt_acknowledge_n = 1; tick(1);
            checks++; if (end_of_interrupt !== 8'h00 || freeze !== 1'b0) begin failures++; $display("FAIL slave_noaeoi: got %h frz=%b expected 00 0", end_of_interrupt, freeze); end
        end
    endtask

    initial begin
        test_reset();
        test_icw_single();
        test_icw_cascade();
        test_ocw1();
        test_ocw2();
        test_ocw3();
        test_acknowledge();
        test_abort();
        test_slave();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
